// File: rtl/fir_pkg.sv
// Shared FIR constants and types used by the filter and its downstream decimator.
package fir_pkg;
    localparam int BIT_PREC       = 8;
    localparam int OUT_SIZE       = 16;
    localparam int DECIM_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic signed [BIT_PREC-1:0] sample_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO whose read/write pointers carry an extra wrap bit, so full and empty can be told apart.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/fir_decim.sv
// Decimates the full-precision FIR output, rounds it half-up to output width and queues it for a valid/ready sink.
// Define FIR_DECIM_SAT_EN to clamp out-of-range results (and pulse sat) instead of wrapping.
module fir_decim
    import fir_pkg::*;
#(
    parameter int IN_W  = OUT_SIZE,
    parameter int OUT_W = BIT_PREC,
    parameter int SHIFT = OUT_SIZE - BIT_PREC,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic [OUT_W-1:0]       m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   sat
);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IN_W:0] RND = (IN_W+1)'(2 ** (SHIFT - 1));

    logic [PH_W-1:0]         phase;
    logic                    keep;
    logic signed [IN_W:0]    in_ext;
    logic signed [IN_W:0]    sum;
    logic signed [IN_W:0]    rnd;
    logic [OUT_W-1:0]        narrow;
    logic                    clamp;
    logic                    stg_vld;
    logic [OUT_W-1:0]        stg_data;
    logic                    stg_sat;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;

    assign keep   = in_valid && (phase == '0);
    // One extra bit of headroom keeps the rounding increment from overflowing.
    assign in_ext = $signed({in_data[IN_W-1], in_data});
    assign sum    = in_ext + RND;
    assign rnd    = sum >>> SHIFT;

`ifdef FIR_DECIM_SAT_EN
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    always_comb begin
        narrow = OUT_W'(rnd);
        clamp  = 1'b0;
        if (rnd > MAXV) begin
            narrow = OUT_W'(MAXV);
            clamp  = 1'b1;
        end else if (rnd < MINV) begin
            narrow = OUT_W'(MINV);
            clamp  = 1'b1;
        end
    end
`else
    assign narrow = OUT_W'(rnd);
    assign clamp  = 1'b0;
`endif

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign sat     = stg_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            stg_vld  <= 1'b0;
            stg_data <= '0;
            stg_sat  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                if (phase == PH_W'(DECIM - 1)) phase <= '0;
                else                          phase <= phase + 1'b1;
            end
            stg_vld  <= keep;
            stg_data <= narrow;
            stg_sat  <= keep && clamp;
            if (stg_vld && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    fir_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stg_vld),
        .pop   (pop),
        .din   (stg_data),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );
endmodule
